// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the keypad matrix emulator.
//   state_e      - press FSM states (IDLE, PRESS, GAP)
//   et_key_t     - one ET-3400 key table entry {valid, row, col}
//   ET3400_MAP   - ET-3400 key table indexed by key code 0..16
//   cnt_w()      - bits needed to hold a count of 0..N
package keypad_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_PRESS, ST_GAP} state_e;

   typedef struct packed {
      logic       vld;
      logic [2:0] row;
      logic [1:0] col;
   } et_key_t;

   localparam int ET_ROWS = 6;
   localparam int ET_COLS = 3;
   localparam int ET_KEYS = 16;

   // Entry 0 is "no key" and stays invalid.
   localparam et_key_t ET3400_MAP [0:ET_KEYS] = '{
      '{1'b0, 3'd0, 2'd0},   // 0
      '{1'b1, 3'd4, 2'd0},   // 1
      '{1'b1, 3'd3, 2'd0},   // 2
      '{1'b1, 3'd2, 2'd0},   // 3
      '{1'b1, 3'd0, 2'd2},   // 4
      '{1'b1, 3'd4, 2'd1},   // 5
      '{1'b1, 3'd3, 2'd1},   // 6
      '{1'b1, 3'd2, 2'd1},   // 7
      '{1'b1, 3'd5, 2'd0},   // 8
      '{1'b1, 3'd4, 2'd2},   // 9
      '{1'b1, 3'd3, 2'd2},   // 10
      '{1'b1, 3'd2, 2'd2},   // 11
      '{1'b1, 3'd0, 2'd1},   // 12
      '{1'b1, 3'd1, 2'd0},   // 13
      '{1'b1, 3'd1, 2'd1},   // 14
      '{1'b1, 3'd1, 2'd2},   // 15
      '{1'b1, 3'd0, 2'd0}    // 16
   };

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/keypad_code_map.sv
// keypad_code_map: combinational key code -> {valid, row, col}.
//   code_i [CODE_W] - key code, 0 = none
//   vld_o           - code names a real key
//   row_o  [RW]     - matrix row of the key
//   col_o  [CW]     - matrix column of the key
// Macro KEYMAP_ET3400_EN selects the ET-3400 code table (requires a 6x3
// matrix); otherwise code k maps linearly: col=(k-1)/ROWS, row=(k-1)%ROWS.
module keypad_code_map
   import keypad_pkg::*;
#(
   parameter int ROWS   = 6,
   parameter int COLS   = 3,
   parameter int CODE_W = 5,
   parameter int RW     = 3,
   parameter int CW     = 2
) (
   input  logic [CODE_W-1:0] code_i,
   output logic              vld_o,
   output logic [RW-1:0]     row_o,
   output logic [CW-1:0]     col_o
);

`ifdef KEYMAP_ET3400_EN
   if (ROWS != ET_ROWS || COLS != ET_COLS) begin : g_bad_geometry
      $error("KEYMAP_ET3400_EN needs ROWS=6 and COLS=3");
   end

   et_key_t ent;

   always_comb begin
      ent   = ET3400_MAP[0];
      vld_o = 1'b0;
      row_o = '0;
      col_o = '0;
      if (int'(code_i) <= ET_KEYS) begin
         ent   = ET3400_MAP[code_i];
         vld_o = ent.vld;
         row_o = RW'(ent.row);
         col_o = CW'(ent.col);
      end
   end
`else
   localparam int KEYS = ROWS * COLS;

   int k;

   always_comb begin
      k     = int'(code_i) - 1;
      vld_o = (code_i != '0) && (int'(code_i) <= KEYS);
      row_o = '0;
      col_o = '0;
      if (vld_o) begin
         row_o = RW'(k % ROWS);
         col_o = CW'(k / ROWS);
      end
   end
`endif

endmodule

// File: rtl/keypad_matrix_emulator.sv
// keypad_matrix_emulator: presses one key at a time on an active-low
// row/column matrix scanned by the ET-3400 CPU.
//   Clock, Reset           - system clock, async active-high reset
//   Key_Valid/Key_Code     - key request (code 0 = none)
//   Key_Ready              - request can be accepted (IDLE)
//   Key_Busy               - press or gap in progress
//   Key_Error              - 1-cycle pulse after an invalid code is accepted
//   Key_Timeout            - 1-cycle pulse on a forced release
//   Keyb_Col_I [COLS]      - active-low column strobes from the CPU
//   Keyb_Row_O [ROWS]      - active-low row returns, registered
// Macro KEYMAP_ET3400_EN selects the ET-3400 code table in keypad_code_map.
module keypad_matrix_emulator
   import keypad_pkg::*;
#(
   parameter int ROWS           = 6,
   parameter int COLS           = 3,
   parameter int HOLD_CYCLES    = 50000,
   parameter int MIN_SCANS      = 2,
   parameter int TIMEOUT_CYCLES = 2000000,
   parameter int GAP_CYCLES     = 50000,
   parameter int CODE_W         = $clog2(ROWS*COLS+1)
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Key_Valid,
   input  logic [CODE_W-1:0] Key_Code,
   output logic              Key_Ready,
   output logic              Key_Busy,
   output logic              Key_Error,
   output logic              Key_Timeout,
   input  logic [COLS-1:0]   Keyb_Col_I,
   output logic [ROWS-1:0]   Keyb_Row_O
);

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int HW = cnt_w(TIMEOUT_CYCLES);
   localparam int SW = cnt_w(MIN_SCANS);
   localparam int GW = cnt_w(GAP_CYCLES);

   state_e          state_q, state_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic [SW-1:0]   scan_q, scan_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [RW-1:0]   row_q, row_d;
   logic [CW-1:0]   col_q, col_d;
   logic [ROWS-1:0] rowo_q, rowo_d;
   logic            err_q, err_d;
   logic [COLS-1:0] sync1_q, sync2_q, prev_q;

   logic            map_vld;
   logic [RW-1:0]   map_row;
   logic [CW-1:0]   map_col;
   logic            accept, fall, done_ok, done_to, tmo;

   keypad_code_map #(
      .ROWS(ROWS), .COLS(COLS), .CODE_W(CODE_W), .RW(RW), .CW(CW)
   ) u_map (
      .code_i (Key_Code),
      .vld_o  (map_vld),
      .row_o  (map_row),
      .col_o  (map_col)
   );

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         hold_q  <= '0;
         scan_q  <= '0;
         gap_q   <= '0;
         row_q   <= '0;
         col_q   <= '0;
         rowo_q  <= '1;
         err_q   <= 1'b0;
         sync1_q <= '1;
         sync2_q <= '1;
         prev_q  <= '1;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         scan_q  <= scan_d;
         gap_q   <= gap_d;
         row_q   <= row_d;
         col_q   <= col_d;
         rowo_q  <= rowo_d;
         err_q   <= err_d;
         sync1_q <= Keyb_Col_I;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   always_comb begin
      accept  = Key_Valid && (state_q == ST_IDLE);
      // Strobe start on the selected column, after synchronisation.
      fall    = prev_q[col_q] && !sync2_q[col_q];
      done_ok = (hold_q >= HW'(HOLD_CYCLES - 1)) && (scan_q == SW'(MIN_SCANS));
      done_to = (hold_q == HW'(TIMEOUT_CYCLES - 1));

      state_d = state_q;
      hold_d  = hold_q;
      scan_d  = scan_q;
      gap_d   = gap_q;
      row_d   = row_q;
      col_d   = col_q;
      err_d   = 1'b0;
      tmo     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               err_d = !map_vld;
               if (map_vld) begin
                  state_d = ST_PRESS;
                  hold_d  = '0;
                  scan_d  = '0;
                  row_d   = map_row;
                  col_d   = map_col;
               end
            end
         end
         ST_PRESS: begin
            if (done_ok || done_to) begin
               // Edges seen on the exit cycle are dropped with the key.
               state_d = ST_GAP;
               gap_d   = '0;
               tmo     = !done_ok;
            end else begin
               if (hold_q != HW'(TIMEOUT_CYCLES)) hold_d = hold_q + HW'(1);
               if (fall && (scan_q != SW'(MIN_SCANS))) scan_d = scan_q + SW'(1);
            end
         end
         ST_GAP: begin
            if (gap_q == GW'(GAP_CYCLES - 1)) state_d = ST_IDLE;
            else                              gap_d   = gap_q + GW'(1);
         end
         default: state_d = ST_IDLE;
      endcase

      // Gated on staying in PRESS so the row is already released in the
      // first GAP cycle rather than lagging one register behind.
      rowo_d = '1;
      if ((state_q == ST_PRESS) && (state_d == ST_PRESS) && !sync2_q[col_q])
         rowo_d[row_q] = 1'b0;
   end

   assign Key_Ready   = (state_q == ST_IDLE);
   assign Key_Busy    = (state_q != ST_IDLE);
   assign Key_Error   = err_q;
   assign Key_Timeout = tmo;
   assign Keyb_Row_O  = rowo_q;

endmodule
